// File: rtl/dmi_jtag_dr.sv
// dmi_jtag_dr: RISC-V debug DTMCS/DMI data registers behind the JTAG TAP.
// Runs entirely on TCK. It turns completed DMI scans into valid/ready
// requests towards the debug module and returns shift-register bit 0 on TDO.
// Ports:
//   clk_i, rst_i              TCK and synchronous active-high reset
//   jtag_*_i                  TAP capture/shift/update strobes and TDI
//   dtmcs_select_i/dmi_select_i  IR decode, gate the strobes
//   dtmcs_tdo_o/dmi_tdo_o     serial out (sr[0])
//   dmi_req_*                 request channel (addr, data, op 1=rd 2=wr)
//   dmi_resp_*                response channel (data, resp 0=ok 2=fail)
//   dmi_hardreset_o           one-cycle pulse on DTMCS.dmihardreset write
module dmi_jtag_dr #(
  parameter int AbitsWidth = 7,
  parameter int IdleCycles = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jtag_capture_i,
  input  logic                  jtag_shift_i,
  input  logic                  jtag_update_i,
  input  logic                  jtag_tdi_i,
  input  logic                  dtmcs_select_i,
  input  logic                  dmi_select_i,
  output logic                  dtmcs_tdo_o,
  output logic                  dmi_tdo_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [AbitsWidth-1:0] dmi_req_addr_o,
  output logic [31:0]           dmi_req_data_o,
  output logic [1:0]            dmi_req_op_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  logic [31:0]           dmi_resp_data_i,
  input  logic [1:0]            dmi_resp_resp_i,
  output logic                  dmi_hardreset_o
);

  localparam int DmiW = AbitsWidth + 34;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state, state_next;
  logic [31:0]           dtmcs_sr;
  logic [DmiW-1:0]       dmi_sr;
  logic [1:0]            err_q, op_q;
  logic [AbitsWidth-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  hardreset_q;

  // strobes only count while their DR is selected
  logic dtmcs_capture, dtmcs_shift, dtmcs_update;
  logic dmi_capture, dmi_shift, dmi_update;
  assign dtmcs_capture = jtag_capture_i & dtmcs_select_i;
  assign dtmcs_shift   = jtag_shift_i   & dtmcs_select_i;
  assign dtmcs_update  = jtag_update_i  & dtmcs_select_i;
  assign dmi_capture   = jtag_capture_i & dmi_select_i;
  assign dmi_shift     = jtag_shift_i   & dmi_select_i;
  assign dmi_update    = jtag_update_i  & dmi_select_i;

  logic hardreset, dmireset, resp_done, busy, busy_hit, dmi_accept;
  logic [1:0] scan_op;
  assign hardreset = dtmcs_update & dtmcs_sr[17];
  assign dmireset  = dtmcs_update & dtmcs_sr[16];
  assign resp_done = (state == RESP) & dmi_resp_valid_i;
  // a response completing this cycle wins over busy detection
  assign busy      = (state != IDLE) & ~resp_done;
  assign busy_hit  = (dmi_capture | dmi_update) & busy;
  assign scan_op   = dmi_sr[1:0];
  assign dmi_accept = dmi_update & (state == IDLE) & (err_q == 2'd0) &
                      ((scan_op == 2'd1) | (scan_op == 2'd2));

  logic [31:0] dtmcs_cap;
  assign dtmcs_cap = {14'b0, 2'b0, 1'b0, 3'(IdleCycles), err_q,
                      6'(AbitsWidth), 4'd1};

  // FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dmi_accept)       state_next = REQ;
      REQ:     if (dmi_req_ready_i)  state_next = RESP;
      RESP:    if (dmi_resp_valid_i) state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
    // hardreset is the only way valid may be withdrawn
    if (hardreset) state_next = IDLE;
  end

  // shift registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dtmcs_sr <= '0;
      dmi_sr   <= '0;
    end else begin
      if (dtmcs_capture)    dtmcs_sr <= dtmcs_cap;
      else if (dtmcs_shift) dtmcs_sr <= {jtag_tdi_i, dtmcs_sr[31:1]};
      if (dmi_capture)      dmi_sr <= {addr_q, data_q, busy ? 2'd3 : err_q};
      else if (dmi_shift)   dmi_sr <= {jtag_tdi_i, dmi_sr[DmiW-1:1]};
    end
  end

  // sticky error: first response failure sticks, busy overrides to 3
  always_ff @(posedge clk_i) begin
    if (rst_i)                                   err_q <= 2'd0;
    else if (hardreset | dmireset)               err_q <= 2'd0;
    else if (resp_done && dmi_resp_resp_i == 2'd2 && err_q == 2'd0)
                                                 err_q <= 2'd2;
    else if (busy_hit)                           err_q <= 2'd3;
  end

  // address/data/op; only reloaded from a scan while IDLE so the request
  // stays stable in REQ and read data survives in RESP
  always_ff @(posedge clk_i) begin
    if (rst_i || hardreset) begin
      addr_q <= '0;
      data_q <= '0;
      op_q   <= 2'd0;
    end else begin
      if (resp_done) begin
        if (op_q == 2'd1) data_q <= dmi_resp_data_i;
      end else if (dmi_update && state == IDLE) begin
        addr_q <= dmi_sr[DmiW-1:34];
        data_q <= dmi_sr[33:2];
      end
      if (dmi_accept) op_q <= scan_op;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) hardreset_q <= 1'b0;
    else       hardreset_q <= hardreset;
  end

  logic unused_bits;
  assign unused_bits = ^{dtmcs_sr[31:18], dtmcs_sr[15:1]};

  assign dtmcs_tdo_o      = dtmcs_sr[0];
  assign dmi_tdo_o        = dmi_sr[0];
  assign dmi_req_valid_o  = (state == REQ);
  assign dmi_resp_ready_o = (state == RESP);
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_req_op_o     = op_q;
  assign dmi_hardreset_o  = hardreset_q;

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed bench for dmi_jtag_dr: DTMCS readout, DMI write/read, busy,
// failure and hardreset scenarios with hand-computed expectations.
module tb_dmi_jtag_dr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic        dtmcs_sel = 1'b0, dmi_sel = 1'b0;
  logic        dtmcs_tdo, dmi_tdo;
  logic        req_valid, req_ready = 1'b0;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        resp_valid = 1'b0, resp_ready;
  logic [31:0] resp_data = '0;
  logic [1:0]  resp_resp = '0;
  logic        hardreset;

  int total = 0;
  int bad   = 0;

  dmi_jtag_dr #(.AbitsWidth(7), .IdleCycles(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .jtag_capture_i(cap), .jtag_shift_i(shf), .jtag_update_i(upd),
    .jtag_tdi_i(tdi), .dtmcs_select_i(dtmcs_sel), .dmi_select_i(dmi_sel),
    .dtmcs_tdo_o(dtmcs_tdo), .dmi_tdo_o(dmi_tdo),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data),
    .dmi_req_op_o(req_op),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp),
    .dmi_hardreset_o(hardreset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // capture, shift len bits LSB first (collecting TDO), optional update
  task automatic scan(input bit sel_dmi, input logic [40:0] din,
                      input bit do_upd, output logic [40:0] dout);
    int len;
    len = sel_dmi ? 41 : 32;
    dout = '0;
    dtmcs_sel = !sel_dmi;
    dmi_sel   = sel_dmi;
    cap = 1'b1; step(); cap = 1'b0;
    shf = 1'b1;
    for (int i = 0; i < len; i++) begin
      dout[i] = sel_dmi ? dmi_tdo : dtmcs_tdo;
      tdi = din[i];
      step();
    end
    shf = 1'b0; tdi = 1'b0;
    if (do_upd) begin upd = 1'b1; step(); upd = 1'b0; end
    dtmcs_sel = 1'b0; dmi_sel = 1'b0;
  endtask

  logic [40:0] d;

  initial begin
    step(); step();
    chk("rst_outs", {req_valid, resp_ready, hardreset, dtmcs_tdo, dmi_tdo,
                     req_addr, req_data, req_op}, '0);
    rst = 1'b0;

    // DTMCS readout: version 1, abits 7, idle 1, dmistat 0
    scan(1'b0, '0, 1'b1, d);
    chk("dtmcs_idle", d[31:0], 64'h1071);
    chk("no_req_after_dtmcs", req_valid, 1'b0);

    // DMI write with ready high
    req_ready = 1'b1;
    scan(1'b1, {7'h10, 32'h1, 2'd2}, 1'b1, d);
    chk("wr_valid", req_valid, 1'b1);
    chk("wr_req", {req_addr, req_data, req_op}, {7'h10, 32'h1, 2'd2});
    step();
    chk("wr_valid_drop", req_valid, 1'b0);
    chk("wr_resp_ready", resp_ready, 1'b1);
    resp_valid = 1'b1; resp_resp = 2'd0; step(); resp_valid = 1'b0;
    chk("wr_resp_ready_drop", resp_ready, 1'b0);
    scan(1'b1, '0, 1'b0, d);
    chk("wr_status", d, {7'h10, 32'h1, 2'd0});

    // DMI read
    scan(1'b1, {7'h11, 32'h0, 2'd1}, 1'b1, d);
    chk("rd_req", {req_valid, req_addr, req_op}, {1'b1, 7'h11, 2'd1});
    step();
    resp_valid = 1'b1; resp_data = 32'hDEADBEEF; step();
    resp_valid = 1'b0; resp_data = '0;
    scan(1'b1, '0, 1'b0, d);
    chk("rd_result", d, {7'h11, 32'hDEADBEEF, 2'd0});

    // Busy: response withheld
    scan(1'b1, {7'h12, 32'hA5A5A5A5, 2'd2}, 1'b1, d);
    step();
    chk("busy_in_resp", resp_ready, 1'b1);
    scan(1'b1, {7'h13, 32'h12345678, 2'd2}, 1'b1, d);
    chk("busy_status", d, {7'h12, 32'hA5A5A5A5, 2'd3});
    chk("busy_no_reissue", req_valid, 1'b0);
    chk("busy_addr_held", req_addr, 7'h12);
    scan(1'b0, '0, 1'b0, d);
    chk("busy_dmistat", d[31:0], 64'h1C71);
    scan(1'b0, 41'h10000, 1'b1, d);
    resp_valid = 1'b1; step(); resp_valid = 1'b0;
    scan(1'b0, '0, 1'b0, d);
    chk("busy_cleared", d[31:0], 64'h1071);
    scan(1'b1, {7'h14, 32'h55, 2'd2}, 1'b1, d);
    chk("after_busy_req", {req_valid, req_addr, req_data, req_op},
        {1'b1, 7'h14, 32'h55, 2'd2});
    step();
    resp_valid = 1'b1; step(); resp_valid = 1'b0;

    // Failure response
    scan(1'b1, {7'h20, 32'h9, 2'd2}, 1'b1, d);
    step();
    resp_valid = 1'b1; resp_resp = 2'd2; step();
    resp_valid = 1'b0; resp_resp = 2'd0;
    scan(1'b0, '0, 1'b0, d);
    chk("fail_dmistat", d[31:0], 64'h1871);
    scan(1'b1, {7'h21, 32'h7, 2'd2}, 1'b1, d);
    chk("fail_op_ignored", req_valid, 1'b0);
    step();
    chk("fail_still_idle", {req_valid, resp_ready}, 2'b00);
    scan(1'b0, 41'h10000, 1'b1, d);
    scan(1'b0, '0, 1'b0, d);
    chk("fail_cleared", d[31:0], 64'h1071);

    // Hardreset while stalled in REQ
    req_ready = 1'b0;
    scan(1'b1, {7'h30, 32'h77, 2'd2}, 1'b1, d);
    chk("hr_valid", req_valid, 1'b1);
    step();
    chk("hr_valid_held", {req_valid, req_addr, req_data}, {1'b1, 7'h30, 32'h77});
    scan(1'b0, 41'h20000, 1'b1, d);
    chk("hr_pulse", hardreset, 1'b1);
    chk("hr_valid_drop", {req_valid, resp_ready}, 2'b00);
    chk("hr_regs_clear", {req_addr, req_data}, '0);
    step();
    chk("hr_pulse_end", hardreset, 1'b0);
    scan(1'b0, '0, 1'b0, d);
    chk("hr_err_clear", d[31:0], 64'h1071);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
